// File: rtl/mips_uart_tx.sv
// mips_uart_tx: memory-mapped 8N1 UART transmitter with a transmit FIFO on the core data-memory port
module mips_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    output logic        hit,
    output logic [31:0] readdata,
    output logic        txd
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_nxt;
    logic [7:0]      fifo [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [4:0]      count5;
    logic [15:0]     div, eff_div, bit_cnt, bit_cnt_nxt;
    logic [2:0]      bit_idx, bit_idx_nxt;
    logic [7:0]      shift, shift_nxt;
    logic [1:0]      sel;
    logic            txd_nxt, ovf, busy, full, empty;
    logic            wr_tx, wr_status, wr_div, push, pop, bit_end;
    logic            unused_bits;

    assign unused_bits = ^{memaddr[1:0], memwritedata[31:16]};

    assign sel       = memaddr[3:2];
    assign hit       = (memaddr[31:4] == BASE_ADDR[31:4]) && (sel != 2'b11);
    assign wr_tx     = hit && memwrite && (sel == 2'd0);
    assign wr_status = hit && memwrite && (sel == 2'd1);
    assign wr_div    = hit && memwrite && (sel == 2'd2);
    assign full      = count == CW'(FIFO_DEPTH);
    assign empty     = count == '0;
    assign push      = wr_tx && !full;
    assign eff_div   = (div < 16'd2) ? 16'd2 : div;
    assign bit_end   = bit_cnt == 16'd0;
    assign pop       = !empty && ((state == IDLE) || ((state == STOP) && bit_end));
    assign busy      = state != IDLE;
    assign count5    = 5'(count);

    // register read mux; TXDATA and unmapped offsets read as zero
    always_comb begin
        readdata = !hit          ? 32'd0 :
                   (sel == 2'd1) ? {23'd0, count5, ovf, empty, full, busy} :
                   (sel == 2'd2) ? {16'd0, div} : 32'd0;
    end

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= memwritedata[7:0];
    end

    // FIFO pointers/count, sticky overflow flag and baud divisor register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            div    <= DIV_RESET;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (wr_status) ovf <= 1'b0;
            else if (wr_tx && full) ovf <= 1'b1;
            if (wr_div) div <= memwritedata[15:0];
        end
    end

    // TX state register with bit timer, bit index, shifter and registered txd
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            txd     <= 1'b1;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
            txd     <= txd_nxt;
        end
    end

    // next state: the bit timer reloads from the live divisor only at bit boundaries
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt - 16'd1;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        case (state)
            IDLE: begin
                bit_cnt_nxt = bit_cnt;
                if (pop) begin
                    state_nxt   = START;
                    bit_cnt_nxt = eff_div - 16'd1;
                    shift_nxt   = fifo[rd_ptr];
                end
            end
            START: if (bit_end) begin
                state_nxt   = DATA;
                bit_idx_nxt = 3'd0;
                bit_cnt_nxt = eff_div - 16'd1;
            end
            DATA: if (bit_end) begin
                bit_cnt_nxt = eff_div - 16'd1;
                shift_nxt   = shift >> 1;
                bit_idx_nxt = bit_idx + 3'd1;
                if (bit_idx == 3'd7) state_nxt = STOP;
            end
            STOP: if (bit_end) begin
                bit_cnt_nxt = eff_div - 16'd1;
                state_nxt   = pop ? START : IDLE;
                if (pop) shift_nxt = fifo[rd_ptr];
            end
            default: state_nxt = IDLE;
        endcase
    end

    // line level for the upcoming state, registered so txd never glitches
    always_comb begin
        txd_nxt = (state_nxt == START) ? 1'b0 :
                  (state_nxt == DATA)  ? shift_nxt[0] : 1'b1;
    end
endmodule
